// File: rtl/mpu_pkg.sv
// mpu_pkg: shared definitions for the matrix processing unit front end.
//   - element / matrix geometry (int8 elements, 5x5 row-major, 200 bits)
//   - opcode encodings presented on mpu_operation
//   - sequencer FSM state type
package mpu_pkg;

  localparam int unsigned ELEM_W    = 8;
  localparam int unsigned MAT_ELEMS = 25;
  localparam int unsigned MAT_BITS  = MAT_ELEMS * ELEM_W;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_IMUL  = 3'd2;
  localparam logic [2:0] OP_OPP   = 3'd3;
  localparam logic [2:0] OP_TRANS = 3'd4;
  localparam logic [2:0] OP_DET   = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DRAIN
  } mpu_state_e;

endpackage

// File: rtl/mpu_op_seq_drain.sv
// mpu_op_seq_drain: result stream walker for mpu_op_sequencer.
// Walks row/column counters over the active N x N window (column fastest),
// producing the flat element index and last flag, advancing only on an
// accepted beat so index/last hold while the consumer stalls.
// Ports:
//   clock, reset     posedge clock, synchronous active-high reset
//   start            pulse: begin a new stream at index 0
//   size             active dimension N (1..5)
//   det              single-element stream (index 0 only)
//   out_ready        consumer ready
//   out_valid        stream element valid
//   out_index        5*r + c of the current element
//   out_last         current element is the final one
module mpu_op_seq_drain
  import mpu_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] size,
  input  logic       det,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [4:0] out_index,
  output logic       out_last
);

  logic [2:0] r_q, r_d;
  logic [2:0] c_q, c_d;
  logic [4:0] index_q, index_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic [7:0] n_m1;

  assign n_m1 = size - 8'd1;

  always_comb begin
    r_d     = r_q;
    c_d     = c_q;
    index_d = index_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (start) begin
      r_d     = '0;
      c_d     = '0;
      index_d = '0;
      valid_d = 1'b1;
      last_d  = det || (size == 8'd1);
    end else if (valid_q && out_ready) begin
      if (last_q) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        if ({5'b0, c_q} == n_m1) begin
          c_d = '0;
          r_d = r_q + 3'd1;
        end else begin
          c_d = c_q + 3'd1;
        end
        index_d = {2'b0, r_d} * 5'd5 + {2'b0, c_d};
        last_d  = ({5'b0, r_d} == n_m1) && ({5'b0, c_d} == n_m1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q     <= '0;
      c_q     <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      r_q     <= r_d;
      c_q     <= c_d;
      index_q <= index_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_index = index_q;
  assign out_last  = last_q;

endmodule

// File: rtl/mpu_op_sequencer.sv
// mpu_op_sequencer: front-end controller for the MPU operations datapath.
// Holds the A/B operand matrices (5x5 int8, row-major), accepts byte loads
// and one command at a time, issues it to the datapath with a start pulse,
// waits a per-opcode latency, captures the result and streams the active
// N x N elements (or element 0 for det) over a valid/ready handshake.
// Ports:
//   clock, reset                      posedge clock, synchronous active-high reset
//   cmd_valid/ready, cmd_op/size/factor/chain   command channel
//   ld_valid/ready, ld_sel/index/data           operand load channel
//   mpu_operation/matrix_a/matrix_b/size/factor/start   datapath drive
//   mpu_result                         datapath result (same flat layout)
//   out_valid/ready, out_index/data/last         result stream
//   busy                               command in flight
//   error                              one-cycle pulse on rejected cmd/load
// Configuration:
//   MPU_OP_SEQ_CHAIN_EN  when defined, cmd_chain=1 copies the captured
//                        result into A so the next command reuses it.
module mpu_op_sequencer
  import mpu_pkg::*;
#(
  parameter int unsigned LAT_FAST = 2,
  parameter int unsigned LAT_MUL  = 12,
  parameter int unsigned MAX_DIM  = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [7:0]          cmd_size,
  input  logic signed [7:0]   cmd_factor,
  input  logic                cmd_chain,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic                ld_sel,
  input  logic [4:0]          ld_index,
  input  logic signed [7:0]   ld_data,
  output logic [2:0]          mpu_operation,
  output logic [MAT_BITS-1:0] mpu_matrix_a,
  output logic [MAT_BITS-1:0] mpu_matrix_b,
  output logic [7:0]          mpu_size,
  output logic signed [7:0]   mpu_factor,
  output logic                mpu_start,
  input  logic [MAT_BITS-1:0] mpu_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          out_index,
  output logic signed [7:0]   out_data,
  output logic                out_last,
  output logic                busy,
  output logic                error
);

  mpu_state_e          state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [7:0]          size_q, size_d;
  logic [7:0]          factor_q, factor_d;
  logic [MAT_BITS-1:0] a_q, a_d;
  logic [MAT_BITS-1:0] b_q, b_d;
  logic [MAT_BITS-1:0] res_q, res_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                ld_ready_q, ld_ready_d;
  logic                error_q, error_d;
  logic                last_fire;
  logic                cmd_bad;

`ifdef MPU_OP_SEQ_CHAIN_EN
  logic chain_q, chain_d;
`else
  logic unused_chain;
  assign unused_chain = cmd_chain;
`endif

  assign cmd_bad   = (cmd_op == OP_RSVD) || (cmd_size == '0) ||
                     (32'(cmd_size) > MAX_DIM);
  assign last_fire = out_valid && out_ready && out_last;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    size_d      = size_q;
    factor_d    = factor_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    start_d     = 1'b0;
    busy_d      = busy_q;
    cmd_ready_d = cmd_ready_q;
    ld_ready_d  = ld_ready_q;
    error_d     = 1'b0;
`ifdef MPU_OP_SEQ_CHAIN_EN
    chain_d     = chain_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (ld_valid && ld_ready_q) begin
          if (32'(ld_index) < MAT_ELEMS) begin
            for (int unsigned i = 0; i < MAT_ELEMS; i++) begin
              if (32'(ld_index) == i) begin
                if (ld_sel) b_d[ELEM_W*i +: ELEM_W] = ld_data;
                else        a_d[ELEM_W*i +: ELEM_W] = ld_data;
              end
            end
          end else begin
            error_d = 1'b1;
          end
        end
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_bad) begin
            error_d = 1'b1;
          end else begin
            op_d        = cmd_op;
            size_d      = cmd_size;
            factor_d    = cmd_factor;
`ifdef MPU_OP_SEQ_CHAIN_EN
            chain_d     = cmd_chain;
`endif
            state_d     = ST_ISSUE;
            start_d     = 1'b1;
            busy_d      = 1'b1;
            cmd_ready_d = 1'b0;
            ld_ready_d  = 1'b0;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = (op_q == OP_MUL) ? 8'(LAT_MUL) : 8'(LAT_FAST);
      end
      ST_WAIT: begin
        if (cnt_q <= 8'd1) state_d = ST_CAPTURE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_CAPTURE: begin
        res_d   = mpu_result;
`ifdef MPU_OP_SEQ_CHAIN_EN
        if (chain_q) a_d = mpu_result;
`endif
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_fire) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          cmd_ready_d = 1'b1;
          ld_ready_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      size_q      <= '0;
      factor_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      ld_ready_q  <= 1'b1;
      error_q     <= 1'b0;
`ifdef MPU_OP_SEQ_CHAIN_EN
      chain_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      size_q      <= size_d;
      factor_q    <= factor_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      ld_ready_q  <= ld_ready_d;
      error_q     <= error_d;
`ifdef MPU_OP_SEQ_CHAIN_EN
      chain_q     <= chain_d;
`endif
    end
  end

  // Stream starts on the CAPTURE edge, when res_q is loaded.
  mpu_op_seq_drain u_drain (
    .clock     (clock),
    .reset     (reset),
    .start     (state_q == ST_CAPTURE),
    .size      (size_q),
    .det       (op_q == OP_DET),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_index (out_index),
    .out_last  (out_last)
  );

  assign out_data      = res_q[{out_index, 3'b000} +: ELEM_W];
  assign mpu_operation = op_q;
  assign mpu_matrix_a  = a_q;
  assign mpu_matrix_b  = b_q;
  assign mpu_size      = size_q;
  assign mpu_factor    = factor_q;
  assign mpu_start     = start_q;
  assign busy          = busy_q;
  assign cmd_ready     = cmd_ready_q;
  assign ld_ready      = ld_ready_q;
  assign error         = error_q;

endmodule

// File: tb/tb_mpu_op_sequencer.sv
// tb_mpu_op_sequencer: directed self-checking bench for mpu_op_sequencer.
// The bench stands in for the datapath: it computes each expected result
// from its own copy of A/B and presents it on mpu_result.
module tb_mpu_op_sequencer;

  logic         clock = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready;
  logic [2:0]   cmd_op;
  logic [7:0]   cmd_size;
  logic [7:0]   cmd_factor;
  logic         cmd_chain;
  logic         ld_valid, ld_ready, ld_sel;
  logic [4:0]   ld_index;
  logic [7:0]   ld_data;
  logic [2:0]   mpu_operation;
  logic [199:0] mpu_matrix_a, mpu_matrix_b;
  logic [7:0]   mpu_size;
  logic [7:0]   mpu_factor;
  logic         mpu_start;
  logic [199:0] mpu_result;
  logic         out_valid, out_ready;
  logic [4:0]   out_index;
  logic [7:0]   out_data;
  logic         out_last, busy, error;

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;
  int err_cnt   = 0;
  int ma [25];
  int mb [25];
  logic [7:0] exp_res [25];

  always #5 clock = ~clock;

  mpu_op_sequencer #(.LAT_FAST(2), .LAT_MUL(12), .MAX_DIM(5)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_size(cmd_size), .cmd_factor(cmd_factor), .cmd_chain(cmd_chain),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_index(ld_index), .ld_data(ld_data),
    .mpu_operation(mpu_operation), .mpu_matrix_a(mpu_matrix_a),
    .mpu_matrix_b(mpu_matrix_b), .mpu_size(mpu_size), .mpu_factor(mpu_factor),
    .mpu_start(mpu_start), .mpu_result(mpu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_data(out_data), .out_last(out_last), .busy(busy), .error(error)
  );

  always @(posedge clock) begin
    if (mpu_start) start_cnt <= start_cnt + 1;
    if (error)     err_cnt   <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_result();
    for (int i = 0; i < 25; i++) mpu_result[8*i +: 8] = exp_res[i];
  endtask

  function automatic logic [199:0] model_vec(input bit sel);
    logic [199:0] v;
    for (int i = 0; i < 25; i++) v[8*i +: 8] = sel ? 8'(mb[i]) : 8'(ma[i]);
    return v;
  endfunction

  task automatic load(input bit sel, input logic [4:0] idx, input logic [7:0] d);
    int b = 0;
    while (!ld_ready && b < 200) begin tick(); b++; end
    if (!ld_ready) check("ld_wait_timeout", {31'b0, ld_ready}, 1);
    ld_valid = 1'b1; ld_sel = sel; ld_index = idx; ld_data = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] n, input logic [7:0] f);
    int b = 0;
    while (!cmd_ready && b < 200) begin tick(); b++; end
    if (!cmd_ready) check("cmd_wait_timeout", {31'b0, cmd_ready}, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_size = n; cmd_factor = f;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Consumes one result stream, checking index/data/last per beat and
  // that data holds across stalls; ends one cycle after the last beat.
  task automatic drain_expect(input int n, input bit det, input bit toggle);
    int total, k, budget, er;
    logic [7:0] held;
    bit stall;
    total = det ? 1 : n * n;
    k = 0; budget = 0; stall = 1'b0; held = '0;
    out_ready = 1'b1;
    while (k < total && budget < 300) begin
      if (stall && out_valid) check("hold_data", {24'b0, out_data}, {24'b0, held});
      if (out_valid && out_ready) begin
        er = det ? 0 : 5 * (k / n) + (k % n);
        check("out_index", {27'b0, out_index}, er);
        check("out_data", {24'b0, out_data}, {24'b0, exp_res[er]});
        check("out_last", {31'b0, out_last}, {31'b0, k == total - 1});
        k++;
      end
      stall = out_valid && !out_ready;
      held  = out_data;
      tick();
      budget++;
      if (toggle) out_ready = ~out_ready;
    end
    if (k < total) check("drain_timeout", k, total);
    out_ready = 1'b1;
    check("valid_drop", {31'b0, out_valid}, 0);
    check("busy_drop", {31'b0, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0, cyc, sum;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_size = '0; cmd_factor = '0;
    cmd_chain = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0; ld_index = '0; ld_data = '0;
    out_ready = 1'b1; mpu_result = '0;
    for (int i = 0; i < 25; i++) begin ma[i] = 0; mb[i] = 0; exp_res[i] = '0; end
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    check("rst_ld_ready", {31'b0, ld_ready}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_start", {31'b0, mpu_start}, 0);
    check("rst_error", {31'b0, error}, 0);
    check("rst_a_zero", {31'b0, mpu_matrix_a == '0}, 1);
    check("rst_b_zero", {31'b0, mpu_matrix_b == '0}, 1);

    // Add, N=5, full window
    for (int i = 0; i < 25; i++) begin
      load(1'b0, 5'(i), 8'(i)); ma[i] = i;
      load(1'b1, 5'(i), 8'd1);  mb[i] = 1;
    end
    check("load_a", {31'b0, mpu_matrix_a == model_vec(1'b0)}, 1);
    check("load_b", {31'b0, mpu_matrix_b == model_vec(1'b1)}, 1);
    for (int i = 0; i < 25; i++) exp_res[i] = 8'(ma[i] + mb[i]);
    set_result();
    s0 = start_cnt;
    issue(3'd0, 8'd5, 8'd0);
    check("issue_start", {31'b0, mpu_start}, 1);
    check("issue_busy", {31'b0, busy}, 1);
    check("issue_cmd_ready", {31'b0, cmd_ready}, 0);
    check("issue_ld_ready", {31'b0, ld_ready}, 0);
    check("issue_size", {24'b0, mpu_size}, 5);
    drain_expect(5, 1'b0, 1'b0);
    check("add_start_once", start_cnt - s0, 1);

    // Mul, N=2: latency and sparse indices
    for (int i = 0; i < 25; i++) exp_res[i] = 8'(8'h80 | i);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        sum = 0;
        for (int q = 0; q < 2; q++) sum += ma[5*r+q] * mb[5*q+c];
        exp_res[5*r+c] = 8'(sum);
      end
    set_result();
    issue(3'd6, 8'd2, 8'd0);
    check("mul_op", {29'b0, mpu_operation}, 6);
    cyc = 0;
    while (!out_valid && cyc < 60) begin tick(); cyc++; end
    check("mul_latency", cyc, 14);
    drain_expect(2, 1'b0, 1'b0);

    // Imul by -3, N=3, ready toggling
    for (int i = 0; i < 25; i++) exp_res[i] = 8'(-3 * ma[i]);
    set_result();
    issue(3'd2, 8'd3, 8'hFD);
    check("imul_factor", {24'b0, mpu_factor}, 32'h0000_00FD);
    drain_expect(3, 1'b0, 1'b1);

    // Rejected commands and load
    s0 = start_cnt; e0 = err_cnt;
    issue(3'd7, 8'd3, 8'd0);
    check("rsvd_error", {31'b0, error}, 1);
    check("rsvd_busy", {31'b0, busy}, 0);
    tick();
    check("rsvd_error_pulse", {31'b0, error}, 0);
    issue(3'd0, 8'd6, 8'd0);
    check("size6_error", {31'b0, error}, 1);
    check("size6_busy", {31'b0, busy}, 0);
    issue(3'd0, 8'd0, 8'd0);
    check("size0_error", {31'b0, error}, 1);
    load(1'b0, 5'd25, 8'h77);
    check("badidx_error", {31'b0, error}, 1);
    check("badidx_a", {31'b0, mpu_matrix_a == model_vec(1'b0)}, 1);
    tick();
    check("err_pulses", err_cnt - e0, 4);
    check("no_start_on_err", start_cnt - s0, 0);

    // Load stalls while busy, accepted afterwards
    for (int i = 0; i < 25; i++) exp_res[i] = 8'(i + 40);
    exp_res[0] = 8'(ma[0] * mb[0]);
    set_result();
    issue(3'd6, 8'd1, 8'd0);
    tick();
    ld_valid = 1'b1; ld_sel = 1'b1; ld_index = 5'd3; ld_data = 8'h55;
    check("wait_ld_ready", {31'b0, ld_ready}, 0);
    tick(); tick();
    check("wait_no_write", {24'b0, mpu_matrix_b[31:24]}, mb[3]);
    drain_expect(1, 1'b0, 1'b0);
    check("idle_ld_ready", {31'b0, ld_ready}, 1);
    tick();
    ld_valid = 1'b0;
    mb[3] = 32'h55;
    check("late_write", {31'b0, mpu_matrix_b == model_vec(1'b1)}, 1);

    // Det: single beat
    for (int i = 0; i < 25; i++) exp_res[i] = 8'(i + 7);
    set_result();
    issue(3'd5, 8'd3, 8'd0);
    drain_expect(3, 1'b1, 1'b0);

    // Reset mid-drain
    out_ready = 1'b0;
    issue(3'd0, 8'd5, 8'd0);
    cyc = 0;
    while (!out_valid && cyc < 60) begin tick(); cyc++; end
    check("pre_rst_valid", {31'b0, out_valid}, 1);
    out_ready = 1'b1;
    tick(); tick();
    check("pre_rst_index", {27'b0, out_index}, 2);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", {31'b0, out_valid}, 0);
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 1);
    check("mid_rst_a", {31'b0, mpu_matrix_a == '0}, 1);
    check("mid_rst_b", {31'b0, mpu_matrix_b == '0}, 1);
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
